// File: rtl/lint2apb_pkg.sv
// Shared types and constants for the core-side to APB3 bridge.
package lint2apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

  localparam int unsigned DefaultTimeoutCycles = 255;

  // Read data returned on writes, slave errors and timeouts.
  localparam logic [31:0] ErrRdata = 32'h0;

endpackage

// File: rtl/lint2apb_bridge.sv
// Single-outstanding req/gnt/rvalid to APB3 master bridge with an access timeout
// so a peripheral that never raises PREADY cannot stall the core.
module lint2apb_bridge
  import lint2apb_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = 32,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = DefaultTimeoutCycles
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        data_req_i,
  input  logic [APB_ADDR_WIDTH-1:0]   data_addr_i,
  input  logic                        data_we_i,
  input  logic [APB_DATA_WIDTH/8-1:0] data_be_i,
  input  logic [APB_DATA_WIDTH-1:0]   data_wdata_i,
  output logic                        data_gnt_o,
  output logic                        data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0]   data_rdata_o,
  output logic                        data_err_o,
  output logic [APB_ADDR_WIDTH-1:0]   paddr_o,
  output logic [APB_DATA_WIDTH-1:0]   pwdata_o,
  output logic                        pwrite_o,
  output logic                        psel_o,
  output logic                        penable_o,
  input  logic [APB_DATA_WIDTH-1:0]   prdata_i,
  input  logic                        pready_i,
  input  logic                        pslverr_i
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);
  localparam logic [CntW-1:0] CntSat  = {CntW{1'b1}};
  localparam logic [APB_DATA_WIDTH-1:0] ErrData = APB_DATA_WIDTH'(ErrRdata);

  apb_state_e                state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [CntW-1:0]           cnt_q, cnt_d;

  // APB3 carries no strobes; peripheral registers are word-only.
  logic unused_be;
  assign unused_be = ^data_be_i;

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    data_gnt_o = 1'b0;

    unique case (state_q)
      IDLE: begin
        data_gnt_o = data_req_i;
        if (data_req_i) begin
          paddr_d  = data_addr_i;
          pwrite_d = data_we_i;
          pwdata_d = data_wdata_i;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          rdata_d = (pwrite_q || pslverr_i) ? ErrData : prdata_i;
          err_d   = pslverr_i;
          state_d = RESP;
        end else if (cnt_q == CntLast) begin
          rdata_d = ErrData;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (cnt_q != CntSat) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // APB strobes decode straight from the state flops: no path from the req side.
  assign psel_o        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable_o     = (state_q == ACCESS);
  assign data_rvalid_o = (state_q == RESP);
  assign data_rdata_o  = data_rvalid_o ? rdata_q : '0;
  assign data_err_o    = data_rvalid_o & err_q;
  assign paddr_o       = paddr_q;
  assign pwdata_o      = pwdata_q;
  assign pwrite_o      = pwrite_q;

endmodule
